// File: rtl/intc_ctrl_if.sv
// intc_ctrl_if: bundle of the interrupt controller's source, mask and core
// handshake signals.
//   master : drives src, mask_we/mask_wdata, irq_ack, eoi (core / platform side)
//   slave  : drives mask, pending, irq, PC_handler, irq_id, in_service
//            (the controller itself)
interface intc_ctrl_if #(
  parameter int N_SRC = 4
);
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic             irq;
  logic [31:0]      PC_handler;
  logic [IDW-1:0]   irq_id;
  logic             irq_ack;
  logic             eoi;
  logic             in_service;

  modport master (
    output src, mask_we, mask_wdata, irq_ack, eoi,
    input  mask, pending, irq, PC_handler, irq_id, in_service
  );

  modport slave (
    input  src, mask_we, mask_wdata, irq_ack, eoi,
    output mask, pending, irq, PC_handler, irq_id, in_service
  );
endinterface

// File: rtl/intc_ctrl.sv
// intc_ctrl: vectored interrupt controller.
//   Latches N_SRC source lines into pending bits (edge or level capture),
//   gates them with a software enable mask, picks the lowest-index eligible
//   source and presents its handler address on PC_handler with irq=1. A
//   request -> ack -> eoi handshake keeps exactly one interrupt in service.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : intc_ctrl_if.slave (src, mask write, pending/mask status,
//          irq/PC_handler/irq_id request, irq_ack/eoi handshake, in_service)
module intc_ctrl #(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter int          VEC_STRIDE = 4,
  parameter bit          EDGE       = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  intc_ctrl_if.slave   bus
);
  localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

  state_e           state_r,      state_s;
  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] pending_r,    pending_s;
  logic [N_SRC-1:0] mask_r,       mask_s;
  logic             irq_r,        irq_s;
  logic [31:0]      pc_r,         pc_s;
  logic [IDW-1:0]   id_r,         id_s;
  logic             in_service_r, in_service_s;

  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] eligible_s;
  logic [IDW-1:0]   sel_idx_s;
  logic             ack_s;

  // Capture, arbitration and handshake next-state logic.
  always_comb begin
    state_s      = state_r;
    irq_s        = irq_r;
    pc_s         = pc_r;
    id_s         = id_r;
    in_service_s = in_service_r;
    sel_idx_s    = {IDW{1'b0}};

    // src_q resets to 0, so a line already high when reset drops is a rise.
    if (EDGE) begin
      set_s = bus.src & ~src_q_r;
    end else begin
      set_s = bus.src;
    end

    if (bus.mask_we) begin
      mask_s = bus.mask_wdata;
    end else begin
      mask_s = mask_r;
    end

    // Arbitration deliberately uses the registered (old) mask.
    eligible_s = pending_r & mask_r;
    // Descending scan so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sel_idx_s = eligible_s[i] ? IDW'(i) : sel_idx_s;
    end

    ack_s = (state_r == REQ) && bus.irq_ack;
    if (ack_s) begin
      clr_s = {{(N_SRC-1){1'b0}}, 1'b1} << id_r;
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
    // A set on the ack edge wins over the clear.
    pending_s = (pending_r & ~clr_s) | set_s;

    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          id_s    = sel_idx_s;
          pc_s    = VEC_BASE + (32'(sel_idx_s) * 32'(VEC_STRIDE));
          irq_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Vector is held: no preemption, no withdrawal on mask change.
        if (bus.irq_ack) begin
          irq_s        = 1'b0;
          in_service_s = 1'b1;
          state_s      = SVC;
        end else begin
          state_s = REQ;
        end
      end
      SVC: begin
        if (bus.eoi) begin
          in_service_s = 1'b0;
          state_s      = IDLE;
        end else begin
          state_s = SVC;
        end
      end
      default: begin
        irq_s        = 1'b0;
        in_service_s = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      src_q_r      <= {N_SRC{1'b0}};
      pending_r    <= {N_SRC{1'b0}};
      mask_r       <= {N_SRC{1'b0}};
      irq_r        <= 1'b0;
      pc_r         <= 32'h0000_0000;
      id_r         <= {IDW{1'b0}};
      in_service_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      src_q_r      <= bus.src;
      pending_r    <= pending_s;
      mask_r       <= mask_s;
      irq_r        <= irq_s;
      pc_r         <= pc_s;
      id_r         <= id_s;
      in_service_r <= in_service_s;
    end
  end

  assign bus.mask       = mask_r;
  assign bus.pending    = pending_r;
  assign bus.irq        = irq_r;
  assign bus.PC_handler = pc_r;
  assign bus.irq_id     = id_r;
  assign bus.in_service = in_service_r;
endmodule

// File: tb/tb_intc_ctrl.sv
// tb_intc_ctrl: directed self-checking bench for intc_ctrl (N_SRC=4,
// VEC_BASE=0, VEC_STRIDE=4, rising-edge capture).
module tb_intc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  intc_ctrl_if #(.N_SRC(4)) bus();

  intc_ctrl #(
    .N_SRC(4), .VEC_BASE(32'h0000_0000), .VEC_STRIDE(4), .EDGE(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
  endtask

  task automatic eoi_pulse();
    bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
  endtask

  initial begin
    bus.src = 4'h0; bus.mask_we = 1'b0; bus.mask_wdata = 4'h0;
    bus.irq_ack = 1'b0; bus.eoi = 1'b0;

    // Reset state
    step(); step();
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_mask", 32'(bus.mask), 32'h0);
    chk("rst_pc", bus.PC_handler, 32'h0);
    chk("rst_id", 32'(bus.irq_id), 32'h0);
    chk("rst_insvc", 32'(bus.in_service), 32'h0);
    rst = 1'b0;

    // 1: single source 2
    bus.mask_we = 1'b1; bus.mask_wdata = 4'hF; step(); bus.mask_we = 1'b0;
    chk("t1_mask", 32'(bus.mask), 32'hF);
    bus.src = 4'b0100; step(); bus.src = 4'h0;
    chk("t1_pend", 32'(bus.pending), 32'h4);
    chk("t1_irq_early", 32'(bus.irq), 32'h0);
    step();
    chk("t1_irq", 32'(bus.irq), 32'h1);
    chk("t1_pc", bus.PC_handler, 32'h8);
    chk("t1_id", 32'(bus.irq_id), 32'h2);
    ack_pulse();
    chk("t1_ack_irq", 32'(bus.irq), 32'h0);
    chk("t1_ack_insvc", 32'(bus.in_service), 32'h1);
    chk("t1_ack_pend", 32'(bus.pending), 32'h0);
    eoi_pulse();
    chk("t1_eoi_insvc", 32'(bus.in_service), 32'h0);

    // 2: simultaneous sources 1 and 3
    bus.src = 4'b1010; step(); bus.src = 4'h0;
    step();
    chk("t2_pc1", bus.PC_handler, 32'h4);
    chk("t2_id1", 32'(bus.irq_id), 32'h1);
    ack_pulse();
    chk("t2_pend", 32'(bus.pending), 32'h8);
    eoi_pulse();
    chk("t2_gap_irq", 32'(bus.irq), 32'h0);
    step();
    chk("t2_irq3", 32'(bus.irq), 32'h1);
    chk("t2_pc3", bus.PC_handler, 32'hC);
    chk("t2_id3", 32'(bus.irq_id), 32'h3);

    // 4: higher-priority arrival while in REQ does not preempt
    bus.src = 4'b0001; step(); bus.src = 4'h0;
    chk("t4_pend", 32'(bus.pending), 32'h9);
    chk("t4_hold_pc", bus.PC_handler, 32'hC);
    step();
    chk("t4_hold_pc2", bus.PC_handler, 32'hC);
    chk("t4_hold_id", 32'(bus.irq_id), 32'h3);
    ack_pulse();
    eoi_pulse();
    step();
    chk("t4_irq0", 32'(bus.irq), 32'h1);
    chk("t4_pc0", bus.PC_handler, 32'h0);
    chk("t4_id0", 32'(bus.irq_id), 32'h0);
    ack_pulse();
    eoi_pulse();

    // 3: masked source latches but is not delivered until enabled
    bus.mask_we = 1'b1; bus.mask_wdata = 4'h0; step(); bus.mask_we = 1'b0;
    bus.src = 4'b0001; step(); bus.src = 4'h0;
    step();
    chk("t3_pend", 32'(bus.pending), 32'h1);
    chk("t3_irq_masked", 32'(bus.irq), 32'h0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'h1; step(); bus.mask_we = 1'b0;
    chk("t3_mask", 32'(bus.mask), 32'h1);
    chk("t3_irq_oldmask", 32'(bus.irq), 32'h0);
    step();
    chk("t3_irq", 32'(bus.irq), 32'h1);
    chk("t3_pc", bus.PC_handler, 32'h0);
    ack_pulse();
    eoi_pulse();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'hF; step(); bus.mask_we = 1'b0;

    // 5: re-set on the ack edge wins over clear
    bus.src = 4'b0010; step(); bus.src = 4'h0;
    step();
    chk("t5_pc", bus.PC_handler, 32'h4);
    bus.src = 4'b0010; ack_pulse(); bus.src = 4'h0;
    chk("t5_pend_kept", 32'(bus.pending), 32'h2);
    chk("t5_insvc", 32'(bus.in_service), 32'h1);
    eoi_pulse();
    chk("t5_gap_irq", 32'(bus.irq), 32'h0);
    step();
    chk("t5_redeliver_irq", 32'(bus.irq), 32'h1);
    chk("t5_redeliver_pc", bus.PC_handler, 32'h4);
    // eoi together with ack is ignored
    bus.eoi = 1'b1; ack_pulse(); bus.eoi = 1'b0;
    chk("t5_eoi_with_ack", 32'(bus.in_service), 32'h1);

    // 6: reset in SVC discards everything
    bus.src = 4'b0100; step(); bus.src = 4'h0;
    chk("t6_pend", 32'(bus.pending), 32'h4);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_irq", 32'(bus.irq), 32'h0);
    chk("t6_pend_rst", 32'(bus.pending), 32'h0);
    chk("t6_mask_rst", 32'(bus.mask), 32'h0);
    chk("t6_insvc_rst", 32'(bus.in_service), 32'h0);
    chk("t6_pc_rst", bus.PC_handler, 32'h0);
    chk("t6_id_rst", 32'(bus.irq_id), 32'h0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'hF; step(); bus.mask_we = 1'b0;
    bus.eoi = 1'b1; bus.irq_ack = 1'b1; step(); bus.eoi = 1'b0; bus.irq_ack = 1'b0;
    step();
    chk("t6_stray_irq", 32'(bus.irq), 32'h0);
    chk("t6_stray_insvc", 32'(bus.in_service), 32'h0);
    chk("t6_stray_pend", 32'(bus.pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
